// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
package riscv_core_pkg;

  localparam int unsigned MDU_W  = 64;
  localparam int unsigned MDU_HW = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  // W-op results are the sign extension of their low half.
  function automatic logic [MDU_W-1:0] sext_w(input logic word, input logic [MDU_W-1:0] v);
    return word ? {{MDU_HW{v[MDU_HW-1]}}, v[MDU_HW-1:0]} : v;
  endfunction

endpackage

// File: rtl/riscv_core_mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
module riscv_core_mdu_divider
  import riscv_core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             word,
  input  logic [MDU_W-1:0] dividend,
  input  logic [MDU_W-1:0] divisor,
  output logic [MDU_W-1:0] quotient,
  output logic [MDU_W-1:0] remainder,
  output logic             last
);

  localparam int unsigned CW = 6;

  logic [MDU_W-1:0] rem_q, quo_q, dsr_q;
  logic [CW-1:0]    count_q;
  logic             active_q;
  logic             word_q;

  logic [MDU_W:0]   shifted;
  logic             ge;
  logic [MDU_W-1:0] rem_nxt, quo_nxt;

  // Quotient/remainder outputs reflect the state after the current step.
  always_comb begin
    shifted  = {rem_q, quo_q[MDU_W-1]};
    ge       = (shifted >= {1'b0, dsr_q});
    rem_nxt  = ge ? MDU_W'(shifted - {1'b0, dsr_q}) : shifted[MDU_W-1:0];
    quo_nxt  = {quo_q[MDU_W-2:0], ge};
    quotient = word_q ? {{MDU_HW{1'b0}}, quo_nxt[MDU_HW-1:0]} : quo_nxt;
    remainder = rem_nxt;
    last     = active_q && (count_q == '0);
  end

  // A 32-bit dividend is parked in the upper half so it shifts out first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
      word_q   <= 1'b0;
    end else if (load) begin
      rem_q    <= '0;
      quo_q    <= word ? {dividend[MDU_HW-1:0], {MDU_HW{1'b0}}} : dividend;
      dsr_q    <= divisor;
      count_q  <= word ? CW'(MDU_HW - 1) : CW'(MDU_W - 1);
      active_q <= 1'b1;
      word_q   <= word;
    end else if (active_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (count_q == '0) active_q <= 1'b0;
      else               count_q  <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/riscv_core_mdu.sv
// RV64M multiply/divide unit for the EX stage with hazard-unit busy/done handshake.
module riscv_core_mdu
  import riscv_core_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            i_mdu_clk,
  input  logic            i_mdu_rst_n,
  input  logic            i_mdu_start,
  input  logic [2:0]      i_mdu_funct3,
  input  logic            i_mdu_word,
  input  logic [XLEN-1:0] i_mdu_srca,
  input  logic [XLEN-1:0] i_mdu_srcb,
  input  logic            i_mdu_flush,
  input  logic            i_mdu_ex_stall,
  output logic [XLEN-1:0] o_mdu_result,
  output logic            o_mdu_busy,
  output logic            o_mdu_done
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned PW = 2 * XLEN;

  mdu_state_t             state_q;
  logic [2:0]             op_q;
  logic                   word_q, neg_q_q, neg_r_q;
  logic signed [XLEN:0]   mul_a_q, mul_b_q;
  logic [XLEN-1:0]        result_q;

  logic                   launch, is_div, sgn_div, a_neg, b_neg;
  logic                   div_zero, div_ovf, div_load, mul_sa, mul_sb;
  logic [XLEN-1:0]        a_w, b_w, a_mag, b_mag, int_min, special_res;
  logic [PW-1:0]          prod;
  logic [XLEN-1:0]        mul_res, div_q, div_r, q_fix, r_fix, div_res;
  logic                   div_last;

  // Operand conditioning for a launch from IDLE.
  always_comb begin
    launch  = (state_q == IDLE) && i_mdu_start && !i_mdu_flush;
    is_div  = i_mdu_funct3[2];
    sgn_div = !i_mdu_funct3[0];
    a_w     = i_mdu_srca;
    b_w     = i_mdu_srcb;
    if (i_mdu_word) begin
      a_w = {{HW{sgn_div & i_mdu_srca[HW-1]}}, i_mdu_srca[HW-1:0]};
      b_w = {{HW{sgn_div & i_mdu_srcb[HW-1]}}, i_mdu_srcb[HW-1:0]};
    end
    int_min  = i_mdu_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    a_neg    = sgn_div && a_w[XLEN-1];
    b_neg    = sgn_div && b_w[XLEN-1];
    a_mag    = a_neg ? (~a_w + XLEN'(1)) : a_w;
    b_mag    = b_neg ? (~b_w + XLEN'(1)) : b_w;
    div_zero = (b_w == '0);
    div_ovf  = sgn_div && (a_w == int_min) && (b_w == '1);
    div_load = launch && is_div && !div_zero && !div_ovf;
    mul_sa   = (i_mdu_funct3 == MDU_MULH) || (i_mdu_funct3 == MDU_MULHSU);
    mul_sb   = (i_mdu_funct3 == MDU_MULH);
    if (div_zero) special_res = i_mdu_funct3[1] ? a_w : '1;
    else          special_res = i_mdu_funct3[1] ? '0  : a_w;
    special_res = sext_w(i_mdu_word, special_res);
  end

  // Result selection for the multiply and divide completion writes.
  always_comb begin
    prod = PW'(mul_a_q) * PW'(mul_b_q);
    if (word_q)                mul_res = sext_w(1'b1, prod[XLEN-1:0]);
    else if (op_q == MDU_MUL)  mul_res = prod[XLEN-1:0];
    else                       mul_res = prod[PW-1:XLEN];
    q_fix   = neg_q_q ? (~div_q + XLEN'(1)) : div_q;
    r_fix   = neg_r_q ? (~div_r + XLEN'(1)) : div_r;
    div_res = sext_w(word_q, op_q[1] ? r_fix : q_fix);
  end

  riscv_core_mdu_divider u_divider (
    .clk       (i_mdu_clk),
    .rst_n     (i_mdu_rst_n),
    .load      (div_load),
    .word      (i_mdu_word),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  // Control FSM; flush wins over everything, including ex_stall in DONE.
  always_ff @(posedge i_mdu_clk or negedge i_mdu_rst_n) begin
    if (!i_mdu_rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else if (i_mdu_flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            op_q    <= i_mdu_funct3;
            word_q  <= i_mdu_word;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            mul_a_q <= {mul_sa & i_mdu_srca[XLEN-1], i_mdu_srca};
            mul_b_q <= {mul_sb & i_mdu_srcb[XLEN-1], i_mdu_srcb};
            if (!is_div) begin
              state_q <= MUL;
            end else if (div_zero || div_ovf) begin
              result_q <= special_res;
              state_q  <= DONE;
            end else begin
              state_q <= DIV;
            end
          end
        end
        MUL: begin
          result_q <= mul_res;
          state_q  <= DONE;
        end
        DIV: begin
          if (div_last) begin
            result_q <= div_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (!i_mdu_ex_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mdu_busy   = launch || (state_q != IDLE);
  assign o_mdu_done   = (state_q == DONE);
  assign o_mdu_result = result_q;

endmodule

// File: tb/tb_riscv_core_mdu.sv
// Randomized self-checking bench for riscv_core_mdu against an arithmetic reference model.
module tb_riscv_core_mdu;
  import riscv_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, word, flush, ex_stall;
  logic [2:0]  funct3;
  logic [63:0] srca, srcb, result;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_core_mdu #(.XLEN(64)) dut (
    .i_mdu_clk      (clk),
    .i_mdu_rst_n    (rst_n),
    .i_mdu_start    (start),
    .i_mdu_funct3   (funct3),
    .i_mdu_word     (word),
    .i_mdu_srca     (srca),
    .i_mdu_srcb     (srcb),
    .i_mdu_flush    (flush),
    .i_mdu_ex_stall (ex_stall),
    .o_mdu_result   (result),
    .o_mdu_busy     (busy),
    .o_mdu_done     (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M semantics in plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  lo, q, r;
    logic [31:0]  a32, b32, q32, r32;
    if (!f3[2]) begin
      if (w) begin
        lo = a * b;
        return sx32(lo[31:0]);
      end
      ea = (f3 == 3'b001 || f3 == 3'b010) ? {{64{a[63]}}, a} : {64'd0, a};
      eb = (f3 == 3'b001) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      return (f3 == 3'b000) ? p[63:0] : p[127:64];
    end
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (!f3[0]) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      return sx32(f3[1] ? r32 : q32);
    end
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    if (!f3[2]) return 2;
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // Launch one op right after a rising edge; returns at the negedge of its last DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input int stall);
    logic [63:0] exp_res, held;
    int          exp_lat, c;
    bit          busy_ok, hold_ok;
    exp_res = ref_result(f3, w, a, b);
    exp_lat = ref_latency(f3, w, a, b);
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; word = w; srca = a; srcb = b; flush = 1'b0; ex_stall = 1'b0;
    @(negedge clk);
    c = 0;
    busy_ok = busy;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
      busy_ok &= busy;
    end
    check({tag, "_lat"}, 64'(c), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    if (stall > 0) begin
      held = result;
      hold_ok = 1'b1;
      ex_stall = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        hold_ok &= (done === 1'b1) && (busy === 1'b1) && (result === held);
      end
      ex_stall = 1'b0;
      check({tag, "_stall_hold"}, 64'(hold_ok), 64'd1);
    end
  endtask

  task automatic release_op(input string tag);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      5:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;
    rst_n = 1'b1; start = 1'b0; funct3 = 3'd0; word = 1'b0;
    srca = '0; srcb = '0; flush = 1'b0; ex_stall = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", {result[61:0], busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mulh", MDU_MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 0);
    release_op("mulh");
    run_op("div", MDU_DIV, 1'b0, -64'sd7, 64'd2, 0);
    run_op("rem", MDU_REM, 1'b0, -64'sd7, 64'd2, 0);
    run_op("divu_z", MDU_DIVU, 1'b0, 64'd5, 64'd0, 0);
    run_op("remw_ovf", MDU_REM, 1'b1, 64'h0000_0000_8000_0000, '1, 0);
    run_op("divuw", MDU_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0);
    run_op("mulhsu", MDU_MULHSU, 1'b0, '1, '1, 0);
    run_op("stall", MDU_MULHU, 1'b0, '1, '1, 3);
    release_op("stall");

    // Flush at T0+10 of a divide, then a multiply launched at T0+12.
    @(posedge clk); #1;
    start = 1'b1; funct3 = MDU_DIV; word = 1'b0; srca = 64'd1000; srcb = 64'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_idle", {62'd0, busy, done}, 64'd0);
    run_op("after_flush", MDU_MUL, 1'b0, 64'd123456789, 64'd987654321, 0);
    release_op("after_flush");

    // Flush in the launch cycle suppresses the launch.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = MDU_DIVU; srca = 64'd9; srcb = 64'd3;
    @(negedge clk);
    check("flush_launch_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_launch_idle", {62'd0, busy, done}, 64'd0);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; funct3 = MDU_DIVU; word = 1'b0; srca = '1; srcb = 64'd3;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0;
    #1 check("reset_mid_div", {result[61:0], busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset", {62'd0, busy, done}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_f%0d_w%0d", i, f3, w), f3, w, a, b, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) release_op($sformatf("rnd%0d", i));
    end
    release_op("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
